sd_hashfunc: RTL

Pipelined, flow-controlled hash unit for the bridge lookup path. It accepts a key on a srdy/drdy consumer interface and folds it into a `log2(table_sz)`-bit bucket index using XOR reduction. Two runtime modes are supported: plain fold and rotated fold, each with a programmable seed. The original key and its hash are presented together on a srdy/drdy producer interface. The block sits between the packet parser and the hash-table lookup engine and sustains one key per clock.

---
 rtl/sd_hashfunc_if.sv | 27 ++
 rtl/sd_hashfunc.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sd_hashfunc_if.sv
// Key/result streaming interface for sd_hashfunc: srdy/drdy consumer side
// (key plus per-key config) and srdy/drdy producer side (key plus bucket index).
interface sd_hashfunc_if #(
   parameter int input_sz = 48,
   parameter int fsz      = 10
);
   logic                c_srdy;
   logic                c_drdy;
   logic [input_sz-1:0] c_key;
   logic                cfg_mode;
   logic [fsz-1:0]      cfg_seed;

   logic                p_srdy;
   logic                p_drdy;
   logic [input_sz-1:0] p_key;
   logic [fsz-1:0]      p_hash;

   modport slave (
      input  c_srdy, c_key, cfg_mode, cfg_seed, p_drdy,
      output c_drdy, p_srdy, p_key, p_hash
   );

   modport master (
      output c_srdy, c_key, cfg_mode, cfg_seed, p_drdy,
      input  c_drdy, p_srdy, p_key, p_hash
   );
endinterface

// File: rtl/sd_hashfunc.sv
// Two-stage XOR-fold hash unit (plain or rotated fold, per-key seed), one key per clock.
// Optional handshake counter enabled by defining SD_HASH_STATS_EN.
module sd_hashfunc #(
   parameter int input_sz = 48,
   parameter int table_sz = 1024
) (
   input  logic             clk,
   input  logic             reset,
   sd_hashfunc_if.slave     io
`ifdef SD_HASH_STATS_EN
   ,
   input  logic             stat_clear,
   output logic [31:0]      stat_count
`endif
);

   localparam int fsz    = $clog2(table_sz);
   localparam int folds  = (input_sz + fsz - 1) / fsz;
   localparam int ext_sz = folds * fsz;

   logic                s1_v;
   logic [input_sz-1:0] s1_key;
   logic                s1_mode;
   logic [fsz-1:0]      s1_seed;

   logic                s2_v;
   logic [input_sz-1:0] s2_key;
   logic [fsz-1:0]      s2_hash;

   logic [ext_sz-1:0]   key_ext;
   logic [fsz-1:0]      hash_c;
   logic                s2_load;
   logic                c_take;

   function automatic logic [fsz-1:0] rotl(input logic [fsz-1:0] x, input int r);
      logic [2*fsz-1:0] dbl;
      dbl = {x, x} << r;
      return dbl[2*fsz-1 -: fsz];
   endfunction

   // NOTE: every variable driven here gets a default before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      key_ext                 = '0;
      key_ext[input_sz-1:0]   = s1_key;
      hash_c                  = s1_seed;
      for (int f = 0; f < folds; f++) begin
         hash_c = hash_c ^ (s1_mode ? rotl(key_ext[f*fsz +: fsz], f % fsz)
                                    : key_ext[f*fsz +: fsz]);
      end
   end

   // s2 can take s1 when empty or draining; c_drdy is combinational from p_drdy
   // so a full pipe refills in the same cycle it drains.
   assign s2_load   = s1_v & (~s2_v | io.p_drdy);
   assign io.c_drdy = ~s1_v | s2_load;
   assign c_take    = io.c_srdy & io.c_drdy;

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v <= 1'b0;
      end else if (c_take) begin
         s1_v <= 1'b1;
      end else if (s2_load) begin
         s1_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_key  <= '0;
         s1_mode <= 1'b0;
         s1_seed <= '0;
      end else if (c_take) begin
         s1_key  <= io.c_key;
         s1_mode <= io.cfg_mode;
         s1_seed <= io.cfg_seed;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_v <= 1'b0;
      end else if (s2_load) begin
         s2_v <= 1'b1;
      end else if (s2_v && io.p_drdy) begin
         s2_v <= 1'b0;
      end
   end

   // NOTE: the s2 data registers are reset because the outputs they drive
   // must read zero out of reset; they otherwise only change on s2_load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_key  <= '0;
         s2_hash <= '0;
      end else if (s2_load) begin
         s2_key  <= s1_key;
         s2_hash <= hash_c;
      end
   end

   assign io.p_srdy = s2_v;
   assign io.p_key  = s2_key;
   assign io.p_hash = s2_hash;

`ifdef SD_HASH_STATS_EN
   // Clear wins over increment; the count sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_count <= '0;
      end else if (stat_clear) begin
         stat_count <= '0;
      end else if (s2_v && io.p_drdy && (stat_count != 32'hFFFF_FFFF)) begin
         stat_count <= stat_count + 32'd1;
      end
   end
`endif

endmodule
